// File: rtl/axi4lite_to_apb3_bridge.sv
// AXI4-Lite slave to APB3 master bridge, one transaction in flight, alternating write/read arbitration.
// Optional ACCESS-phase timeout is built in when APB_BRIDGE_TIMEOUT_EN is defined.
module axi4lite_to_apb3_bridge #(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  output logic [ADDR_W-1:0] m_paddr,
  output logic [31:0]       m_pwdata,
  input  logic [31:0]       m_prdata,
  input  logic              m_pready,
  input  logic              m_pslverr
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]        r_state, w_state_nxt;
  logic              r_is_wr, w_is_wr_nxt;
  logic              r_prefer_wr, w_prefer_wr_nxt;
  logic              r_psel, w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic              r_pwrite, w_pwrite_nxt;
  logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
  logic              r_bvalid, w_bvalid_nxt;
  logic [1:0]        r_bresp, w_bresp_nxt;
  logic              r_rvalid, w_rvalid_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]        r_rresp, w_rresp_nxt;
`ifdef APB_BRIDGE_TIMEOUT_EN
  logic [CNT_W-1:0]  r_tmo_cnt, w_tmo_cnt_nxt;
`endif

  logic       w_idle, w_wr_pend, w_rd_pend, w_tie;
  logic       w_grant_wr, w_grant_rd;
  logic [1:0] w_apb_resp;
  logic       w_unused;

  // Grant only in IDLE and never while reset is asserted; ties go to the type not granted at the last tie.
  assign w_idle     = (r_state == ST_IDLE) && !rst;
  assign w_wr_pend  = s_awvalid && s_wvalid;
  assign w_rd_pend  = s_arvalid;
  assign w_tie      = w_idle && w_wr_pend && w_rd_pend;
  assign w_grant_wr = w_idle && w_wr_pend && (!w_rd_pend || r_prefer_wr);
  assign w_grant_rd = w_idle && w_rd_pend && (!w_wr_pend || !r_prefer_wr);
  assign w_apb_resp = m_pslverr ? RESP_SLVERR : RESP_OKAY;

  assign s_awready = w_grant_wr;
  assign s_wready  = w_grant_wr;
  assign s_arready = w_grant_rd;

  assign m_psel    = r_psel;
  assign m_penable = r_penable;
  assign m_pwrite  = r_pwrite;
  assign m_paddr   = r_paddr;
  assign m_pwdata  = r_pwdata;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

  // Address low bits are dropped by word alignment; the timeout value is only consumed by the timeout build.
  assign w_unused = ^{1'b0, s_awaddr[1:0], s_araddr[1:0], CNT_W'(TIMEOUT_CYCLES)};

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_is_wr_nxt     = r_is_wr;
    w_prefer_wr_nxt = r_prefer_wr;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_bvalid_nxt    = r_bvalid;
    w_bresp_nxt     = r_bresp;
    w_rvalid_nxt    = r_rvalid;
    w_rdata_nxt     = r_rdata;
    w_rresp_nxt     = r_rresp;
`ifdef APB_BRIDGE_TIMEOUT_EN
    w_tmo_cnt_nxt   = r_tmo_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_tie) w_prefer_wr_nxt = !r_prefer_wr;
        if (w_grant_wr) begin
          w_is_wr_nxt = 1'b1;
          if (s_wstrb == 4'hF) begin
            w_state_nxt  = ST_SETUP;
            w_psel_nxt   = 1'b1;
            w_pwrite_nxt = 1'b1;
            w_paddr_nxt  = {s_awaddr[ADDR_W-1:2], 2'b00};
            w_pwdata_nxt = s_wdata;
          end else begin
            // Partial strobes are refused without touching the APB bus.
            w_state_nxt  = ST_RESP;
            w_bvalid_nxt = 1'b1;
            w_bresp_nxt  = RESP_SLVERR;
          end
        end else if (w_grant_rd) begin
          w_is_wr_nxt  = 1'b0;
          w_state_nxt  = ST_SETUP;
          w_psel_nxt   = 1'b1;
          w_pwrite_nxt = 1'b0;
          w_paddr_nxt  = {s_araddr[ADDR_W-1:2], 2'b00};
          w_pwdata_nxt = '0;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_penable_nxt = 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
        w_tmo_cnt_nxt = '0;
`endif
      end
      ST_ACCESS: begin
        if (m_pready) begin
          w_state_nxt   = ST_RESP;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          if (r_is_wr) begin
            w_bvalid_nxt = 1'b1;
            w_bresp_nxt  = w_apb_resp;
          end else begin
            w_rvalid_nxt = 1'b1;
            w_rdata_nxt  = m_prdata;
            w_rresp_nxt  = w_apb_resp;
          end
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt   = ST_RESP;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          if (r_is_wr) begin
            w_bvalid_nxt = 1'b1;
            w_bresp_nxt  = RESP_SLVERR;
          end else begin
            w_rvalid_nxt = 1'b1;
            w_rdata_nxt  = '0;
            w_rresp_nxt  = RESP_SLVERR;
          end
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (r_is_wr ? s_bready : s_rready) begin
          w_state_nxt  = ST_IDLE;
          w_bvalid_nxt = 1'b0;
          w_rvalid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_wr     <= 1'b0;
      r_prefer_wr <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= 2'b00;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= 2'b00;
`ifdef APB_BRIDGE_TIMEOUT_EN
      r_tmo_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_is_wr     <= w_is_wr_nxt;
      r_prefer_wr <= w_prefer_wr_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_bvalid    <= w_bvalid_nxt;
      r_bresp     <= w_bresp_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rresp     <= w_rresp_nxt;
`ifdef APB_BRIDGE_TIMEOUT_EN
      r_tmo_cnt   <= w_tmo_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_axi4lite_to_apb3_bridge.sv
// Self-checking bench for axi4lite_to_apb3_bridge: directed table, tie/reset sequences and
// randomized traffic against a transaction-level model with an APB slave memory.
module tb_axi4lite_to_apb3_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [10:0] s_awaddr, s_araddr, m_paddr;
  logic [31:0] s_wdata, s_rdata, m_pwdata, m_prdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;

  axi4lite_to_apb3_bridge #(.ADDR_W(11), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          err;
    int          rdelay;
    bit          exp_apb;
    logic [10:0] exp_paddr;
    logic [31:0] exp_pwdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_psel;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] slv_mem [512];
  logic [31:0] ref_mem [512];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ctl"}, 64'({s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, s_rresp,
                            m_psel, m_penable, m_pwrite, m_paddr}), 64'(0));
    chk({tag, " data"}, {s_rdata, m_pwdata}, 64'(0));
  endtask

  function automatic vec_t mk(input bit is_wr, input logic [10:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int waits, input bit err, input int rdelay,
                              input bit exp_apb, input logic [10:0] exp_paddr, input logic [31:0] exp_pwdata,
                              input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                              input int exp_lat, input int exp_psel);
    vec_t v;
    v.is_wr = is_wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.waits = waits;
    v.err = err; v.rdelay = rdelay; v.exp_apb = exp_apb; v.exp_paddr = exp_paddr;
    v.exp_pwdata = exp_pwdata; v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
    v.exp_lat = exp_lat; v.exp_psel = exp_psel;
    return v;
  endfunction

  // Transaction-level reference: word-aligned address, full strobes only, SLVERR on refusal or slave error.
  function automatic vec_t model(input bit is_wr, input logic [10:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int waits, input bit err, input int rdelay);
    bit apb;
    apb = !is_wr || (strb == 4'hF);
    return mk(is_wr, addr, wdata, strb, waits, err, rdelay, apb,
              11'((int'(addr) / 4) * 4), is_wr ? wdata : 32'h0,
              (!apb || err) ? 2'b10 : 2'b00, ref_mem[int'(addr) / 4],
              apb ? 3 + waits : 1, apb ? 2 + waits : 0);
  endfunction

  task automatic start_txn(input bit is_wr, input logic [10:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
    if (is_wr) begin
      s_awaddr = addr; s_wdata = wdata; s_wstrb = strb; s_awvalid = 1'b1; s_wvalid = 1'b1;
    end else begin
      s_araddr = addr; s_arvalid = 1'b1;
    end
  endtask

  // Plays the APB slave for one transfer and checks the AXI response, stall and release.
  task automatic finish_txn(input bit is_wr, input int waits, input bit err, input int rdelay,
                            input bit exp_apb, input logic [10:0] exp_paddr, input logic [31:0] exp_pwdata,
                            input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                            input int exp_lat, input int exp_psel, input string tag);
    int cyc, psel_n, acc;
    bit done, stable;
    logic [1:0]  resp_s;
    logic [31:0] rdata_s;
    cyc = 0; psel_n = 0; acc = 0; done = 1'b0;
    @(negedge clk);
    cyc = 1;
    if (is_wr) begin s_awvalid = 1'b0; s_wvalid = 1'b0; end else s_arvalid = 1'b0;
    while (!done && cyc < 2000) begin
      if (m_psel && !m_penable) begin
        chk({tag, " paddr"}, 64'(m_paddr), 64'(exp_paddr));
        chk({tag, " pwrite"}, 64'(m_pwrite), 64'(is_wr));
        chk({tag, " pwdata"}, 64'(m_pwdata), 64'(exp_pwdata));
      end
      if (m_psel) psel_n++;
      m_pready = 1'b0; m_pslverr = 1'b0;
      if (m_psel && m_penable) begin
        if (acc == waits) begin
          m_pready = 1'b1; m_pslverr = err;
          m_prdata = slv_mem[m_paddr[10:2]];
          if (m_pwrite && !err) slv_mem[m_paddr[10:2]] = m_pwdata;
        end else m_prdata = $urandom;
        acc++;
      end
      if (is_wr ? s_bvalid : s_rvalid) done = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    m_pready = 1'b0; m_pslverr = 1'b0;
    chk({tag, " done"}, 64'(done), 64'(1));
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " psel_cycles"}, 64'(psel_n), 64'(exp_apb ? exp_psel : 0));
    chk({tag, " resp"}, 64'(is_wr ? s_bresp : s_rresp), 64'(exp_resp));
    if (!is_wr) chk({tag, " rdata"}, 64'(s_rdata), 64'(exp_rdata));
    resp_s = is_wr ? s_bresp : s_rresp; rdata_s = s_rdata; stable = 1'b1;
    repeat (rdelay) begin
      @(negedge clk);
      if (!(is_wr ? s_bvalid : s_rvalid) || (is_wr ? s_bresp : s_rresp) !== resp_s || s_rdata !== rdata_s)
        stable = 1'b0;
    end
    chk({tag, " stall_stable"}, 64'(stable), 64'(1));
    if (is_wr) s_bready = 1'b1; else s_rready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0; s_rready = 1'b0;
    chk({tag, " valid_drop"}, 64'({s_bvalid, s_rvalid}), 64'(0));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start_txn(v.is_wr, v.addr, v.wdata, v.strb);
    #1;
    chk({tag, " accept"}, 64'({s_awready, s_wready, s_arready}), v.is_wr ? 64'(3'b110) : 64'(3'b001));
    finish_txn(v.is_wr, v.waits, v.err, v.rdelay, v.exp_apb, v.exp_paddr, v.exp_pwdata,
               v.exp_resp, v.exp_rdata, v.exp_lat, v.exp_psel, tag);
    if (v.is_wr && v.exp_apb && !v.err) ref_mem[int'(v.addr) / 4] = v.wdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [9];
    vec_t v;
    bit   quiet;
    for (int i = 0; i < 512; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst = 1'b1;
    {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready, m_pready, m_pslverr} = '0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0; m_prdata = '0;

    //          wr  addr    wdata         strb  wt er rd  apb paddr   pwdata        resp   rdata        lat psel
    tbl[0] = mk(1, 11'h203, 32'h000000AB, 4'hF, 0, 0, 10, 1, 11'h200, 32'h000000AB, 2'b00, 32'h0,        3, 2);
    tbl[1] = mk(1, 11'h208, 32'h00000010, 4'hF, 1, 0, 0,  1, 11'h208, 32'h00000010, 2'b00, 32'h0,        4, 3);
    tbl[2] = mk(0, 11'h208, 32'h0,        4'h0, 2, 0, 0,  1, 11'h208, 32'h0,        2'b00, 32'h00000010, 5, 4);
    tbl[3] = mk(1, 11'h10C, 32'hDEADBEEF, 4'h3, 0, 0, 2,  0, 11'h0,   32'h0,        2'b10, 32'h0,        1, 0);
    tbl[4] = mk(0, 11'h10C, 32'h0,        4'h0, 0, 1, 0,  1, 11'h10C, 32'h0,        2'b10, 32'h0,        3, 2);
    tbl[5] = mk(1, 11'h7FF, 32'h12345678, 4'hF, 3, 1, 1,  1, 11'h7FC, 32'h12345678, 2'b10, 32'h0,        6, 5);
    tbl[6] = mk(0, 11'h7FE, 32'h0,        4'h0, 0, 0, 0,  1, 11'h7FC, 32'h0,        2'b00, 32'h0,        3, 2);
    tbl[7] = mk(1, 11'h000, 32'hCAFEF00D, 4'h0, 0, 0, 0,  0, 11'h0,   32'h0,        2'b10, 32'h0,        1, 0);
    tbl[8] = mk(0, 11'h201, 32'h0,        4'h0, 1, 0, 3,  1, 11'h200, 32'h0,        2'b00, 32'h000000AB, 4, 3);

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // First tie after reset goes to the read; the write follows once the bridge is idle.
    start_txn(1, 11'h100, 32'h11111111, 4'hF);
    start_txn(0, 11'h104, 32'h0, 4'h0);
    #1;
    chk("tie1 grant", 64'({s_awready, s_wready, s_arready}), 64'(3'b001));
    finish_txn(0, 0, 0, 0, 1, 11'h104, 32'h0, 2'b00, 32'h0, 3, 2, "tie1_rd");
    #1;
    chk("tie1 wr_grant", 64'({s_awready, s_wready, s_arready}), 64'(3'b110));
    finish_txn(1, 0, 0, 0, 1, 11'h100, 32'h11111111, 2'b00, 32'h0, 3, 2, "tie1_wr");
    ref_mem[11'h100 / 4] = 32'h11111111;

    // Second tie goes to the write.
    start_txn(1, 11'h108, 32'h22222222, 4'hF);
    start_txn(0, 11'h100, 32'h0, 4'h0);
    #1;
    chk("tie2 grant", 64'({s_awready, s_wready, s_arready}), 64'(3'b110));
    finish_txn(1, 1, 0, 0, 1, 11'h108, 32'h22222222, 2'b00, 32'h0, 4, 3, "tie2_wr");
    ref_mem[11'h108 / 4] = 32'h22222222;
    #1;
    chk("tie2 rd_grant", 64'({s_awready, s_wready, s_arready}), 64'(3'b001));
    finish_txn(0, 0, 0, 0, 1, 11'h100, 32'h0, 2'b00, 32'h11111111, 3, 2, "tie2_rd");

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [3:0] strb;
      strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      v = model($urandom_range(0, 1) == 1, 11'($urandom_range(0, 2047)), $urandom, strb,
                $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 3));
      run_vec(v, $sformatf("rnd%0d", i));
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    start_txn(0, 11'h208, 32'h0, 4'h0);
    #1;
    chk("tmo accept", 64'(s_arready), 64'(1));
    finish_txn(0, 100000, 0, 0, 1, 11'h208, 32'h0, 2'b10, 32'h0, 6, 5, "tmo");
`else
    start_txn(0, 11'h208, 32'h0, 4'h0);
    #1;
    chk("hang accept", 64'(s_arready), 64'(1));
    @(negedge clk);
    s_arvalid = 1'b0;
    repeat (1000) @(negedge clk);
    chk("hang still_access", 64'({m_psel, m_penable, s_rvalid}), 64'(3'b110));
    rst = 1'b1;
    @(negedge clk);
    chk_zero("hang_rst");
    rst = 1'b0;
`endif

    // Reset in the middle of ACCESS abandons the write completely.
    start_txn(1, 11'h300, 32'h5A5A5A5A, 4'hF);
    #1;
    chk("midrst accept", 64'({s_awready, s_wready}), 64'(2'b11));
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst in_access", 64'({m_psel, m_penable}), 64'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (m_psel || s_bvalid || s_rvalid) quiet = 1'b0;
    end
    chk("midrst quiet", 64'(quiet), 64'(1));
    v = model(0, 11'h300, 32'h0, 4'h0, 0, 0, 0);
    run_vec(v, "midrst_readback");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi4lite_to_apb3_bridge.md
AXI4LITE_TO_APB3_BRIDGE -- requirements
Module: axi4lite_to_apb3_bridge

Interface
REQ-001 Parameter ADDR_W, default 11, address width of both buses in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, maximum ACCESS-phase wait in cycles, legal range 2..65535.
REQ-003 Ports SHALL be:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- s_awvalid/s_awready  in/out  1/1  AXI write-address handshake
- s_awaddr  input  ADDR_W  write address
- s_wvalid/s_wready  in/out  1/1  AXI write-data handshake
- s_wdata  input  32  write data
- s_wstrb  input  4  byte strobes
- s_bvalid/s_bready  out/in  1/1  write-response handshake
- s_bresp  output  2  write response
- s_arvalid/s_arready  in/out  1/1  read-address handshake
- s_araddr  input  ADDR_W  read address
- s_rvalid/s_rready  out/in  1/1  read-data handshake
- s_rdata  output  32  read data
- s_rresp  output  2  read response
- m_psel, m_penable, m_pwrite  output  1 each  APB3 control
- m_paddr  output  ADDR_W  APB address
- m_pwdata  output  32  APB write data
- m_prdata  input  32  APB read data
- m_pready, m_pslverr  input  1 each  APB completion and error
REQ-004 Reset is rst, synchronous, active-high; clock is clk.

Function
REQ-005 One transaction outstanding at a time; FSM states IDLE, SETUP, ACCESS, RESP.
REQ-006 IDLE: s_awready = s_wready = 1 only when s_awvalid && s_wvalid are both high and the write is granted; AW and W are always accepted in the same cycle.
REQ-007 IDLE: s_arready = 1 only when s_arvalid is high and the read is granted.
REQ-008 Arbitration when write (AW+W) and read are both pending in the same cycle: alternate, granting the type not granted last; after reset a read wins the first tie.
REQ-009 Accept cycle N -> SETUP at N+1 (psel=1, penable=0) -> ACCESS at N+2 (psel=1, penable=1); psel, pwrite, paddr and pwdata are held stable from SETUP through the end of ACCESS.
REQ-010 m_paddr = {addr[ADDR_W-1:2], 2'b00}; m_pwrite = 1 for writes; m_pwdata = captured s_wdata for writes and 0 for reads.
REQ-011 ACCESS ends on the first cycle with m_pready=1; the next cycle psel=penable=0 and the FSM is in RESP with s_bvalid or s_rvalid=1.
REQ-012 A read captures m_prdata into s_rdata at the completing cycle; resp = 2'b10 (SLVERR) if m_pslverr=1, otherwise 2'b00.
REQ-013 A write with s_wstrb != 4'hF performs no APB transfer; the FSM goes IDLE -> RESP directly with s_bresp=2'b10 on the cycle after accept.
REQ-014 RESP: s_bvalid/s_rvalid and their data/resp stay stable until the matching ready is seen; the FSM returns to IDLE on the cycle after that handshake; a new accept is allowed only from IDLE.
REQ-015 Minimum write latency (AXI accept to s_bvalid) is 3 cycles when m_pready is already high in the first ACCESS cycle; read latency is the same.

Reset
REQ-016 Under rst all outputs SHALL be 0 at the next edge (readies, valids, resp, s_rdata, all m_* outputs); FSM = IDLE; arbitration state = read-preferred.
REQ-017 rst asserted mid-transaction drops that transaction with no AXI response and no further APB cycles.

Configuration
REQ-018 Macro APB_BRIDGE_TIMEOUT_EN defined: a counter runs in ACCESS; if m_pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, psel/penable drop, RESP is entered with resp=2'b10, and s_rdata=0 for reads; a late m_pready is ignored.
REQ-019 Macro APB_BRIDGE_TIMEOUT_EN undefined: no counter is present and ACCESS waits indefinitely for m_pready; the TIMEOUT_CYCLES parameter is unused.

Verification
REQ-020 Write awaddr=0x203, wdata=0x000000AB, wstrb=0xF, slave pready on the first ACCESS cycle -> paddr=0x200, pwdata=0xAB, pwrite=1, bresp=00, bvalid 3 cycles after accept.
REQ-021 Read araddr=0x208, slave returns prdata=0x10 after 2 wait cycles -> rdata=0x00000010, rresp=00, psel high for exactly 4 cycles.
REQ-022 AW+W and AR presented in the same cycle immediately after reset -> read transfer first, then write; repeat the tie -> write first.
REQ-023 wstrb=0x3 -> no psel pulse, bresp=2'b10; read with pslverr=1 -> rresp=2'b10.
REQ-024 With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 -> SLVERR after 4 ACCESS cycles, rdata=0; without the macro, the bridge is still in ACCESS after 1000 cycles.
REQ-025 bready held low for 10 cycles, then rst pulsed during a later ACCESS -> bvalid/bresp held stable through the stall; after rst all outputs are 0 and no response is issued.
